// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: FSM encoding and register constants.
package pipe_ctrl_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MD_WAIT  = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, MUL/DIV occupancy, dmem wait and branch flush,
// with stall/flush performance counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MD_MAX_CYC = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_idex,
  input  logic             mem_read_idex,
  input  logic             md_op_idex,
  input  logic             md_done,
  input  logic             dmem_req_exmem,
  input  logic             dmem_ready,
  input  logic             branch_taken_ex,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             md_start,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WdW = (MD_MAX_CYC > 2) ? $clog2(MD_MAX_CYC) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(MD_MAX_CYC - 1);

  logic [1:0]     state_d, state_q;
  logic [WdW-1:0] wd_d, wd_q;
  logic           to_d, to_q;

  logic pc_w, ifid_w, idex_w, exmem_w;
  logic ifid_fl, idex_fl, bubble, start, flush_ev;
  logic load_use;

  assign load_use = mem_read_idex && (rd_idex != REG_ZERO) &&
                    ((use_rs1_id && (rs1_id == rd_idex)) ||
                     (use_rs2_id && (rs2_id == rd_idex)));

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    to_d     = to_q;
    pc_w     = 1'b1;
    ifid_w   = 1'b1;
    idex_w   = 1'b1;
    exmem_w  = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    bubble   = 1'b0;
    start    = 1'b0;
    flush_ev = 1'b0;
    case (state_q)
      RUN: begin
        if (dmem_req_exmem && !dmem_ready) begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          state_d = MEM_WAIT;
        end else if (md_op_idex) begin
          start   = 1'b1;
          {pc_w, ifid_w, idex_w} = 3'b000;
          bubble  = 1'b1;
          wd_d    = '0;
          state_d = MD_WAIT;
        end else if (branch_taken_ex) begin
          ifid_fl  = 1'b1;
          idex_fl  = 1'b1;
          flush_ev = 1'b1;
        end else if (load_use) begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_fl = 1'b1;
        end
      end
      MD_WAIT: begin
        if (md_done) begin
          state_d = RUN;
        end else if (wd_q == WdLast) begin
          // Give up on the unit and let the pipeline drain rather than hang.
          to_d    = 1'b1;
          state_d = RUN;
        end else begin
          {pc_w, ifid_w, idex_w} = 3'b000;
          bubble = 1'b1;
          wd_d   = wd_q + WdW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rstn),
    .en_i   (~pc_w),
    .cnt_o  (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk),
    .rst_ni (rstn),
    .en_i   (flush_ev),
    .cnt_o  (flush_cnt)
  );

  // Everything reads 0 while reset is held, including the Mealy outputs.
  assign pc_write     = pc_w & rstn;
  assign ifid_write   = ifid_w & rstn;
  assign idex_write   = idex_w & rstn;
  assign exmem_write  = exmem_w & rstn;
  assign ifid_flush   = ifid_fl & rstn;
  assign idex_flush   = idex_fl & rstn;
  assign exmem_bubble = bubble & rstn;
  assign md_start     = start & rstn;
  assign md_timeout   = to_q & rstn;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected per-cycle outputs queued at drive, checked at negedge.
module tb_hazard_ctrl;

  localparam int unsigned CntW  = 4;
  localparam int unsigned MdMax = 8;

  // Output vector order: pc, ifid, idex, exmem, ifid_flush, idex_flush, bubble, md_start.
  localparam logic [7:0] ONorm    = 8'b1111_0000;
  localparam logic [7:0] OLoadUse = 8'b0011_0100;
  localparam logic [7:0] OBranch  = 8'b1111_1100;
  localparam logic [7:0] OMdStart = 8'b0001_0011;
  localparam logic [7:0] OMdWait  = 8'b0001_0010;
  localparam logic [7:0] OHold    = 8'b0000_0000;

  logic clk, rstn;
  logic [4:0] rs1_id, rs2_id, rd_idex;
  logic use_rs1_id, use_rs2_id, mem_read_idex, md_op_idex, md_done;
  logic dmem_req_exmem, dmem_ready, branch_taken_ex;
  logic pc_write, ifid_write, idex_write, exmem_write;
  logic ifid_flush, idex_flush, exmem_bubble, md_start, md_timeout;
  logic [CntW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CntW), .MD_MAX_CYC(MdMax)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .use_rs1_id      (use_rs1_id),
    .use_rs2_id      (use_rs2_id),
    .rd_idex         (rd_idex),
    .mem_read_idex   (mem_read_idex),
    .md_op_idex      (md_op_idex),
    .md_done         (md_done),
    .dmem_req_exmem  (dmem_req_exmem),
    .dmem_ready      (dmem_ready),
    .branch_taken_ex (branch_taken_ex),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_write      (idex_write),
    .exmem_write     (exmem_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_bubble    (exmem_bubble),
    .md_start        (md_start),
    .md_timeout      (md_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       md;
    logic       mdd;
    logic       dreq;
    logic       drdy;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic [7:0]      outs;
    logic            to;
    logic [CntW-1:0] stall;
    logic [CntW-1:0] flush;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  stim_t s;
  int errors = 0;
  int checks = 0;
  logic [CntW-1:0] m_stall = '0;
  logic [CntW-1:0] m_flush = '0;
  logic m_to = 1'b0;

  logic [7:0] outs;
  assign outs = {pc_write, ifid_write, idex_write, exmem_write,
                 ifid_flush, idex_flush, exmem_bubble, md_start};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check_eq("outs", 32'(outs), 32'(mon_e.outs));
      check_eq("md_timeout", 32'(md_timeout), 32'(mon_e.to));
      check_eq("stall_cnt", 32'(stall_cnt), 32'(mon_e.stall));
      check_eq("flush_cnt", 32'(flush_cnt), 32'(mon_e.flush));
    end
  end

  // One cycle: drive s, queue the expected outputs, then advance the counter model.
  task automatic step(input logic [7:0] eo, input logic to_next);
    @(posedge clk);
    #1;
    rs1_id = s.rs1; rs2_id = s.rs2; use_rs1_id = s.u1; use_rs2_id = s.u2;
    rd_idex = s.rd; mem_read_idex = s.mr; md_op_idex = s.md; md_done = s.mdd;
    dmem_req_exmem = s.dreq; dmem_ready = s.drdy; branch_taken_ex = s.br;
    sb_q.push_back(exp_t'{outs: eo, to: m_to, stall: m_stall, flush: m_flush});
    if (!eo[7] && (m_stall != {CntW{1'b1}})) m_stall = m_stall + 1'b1;
    if (eo[3] && (m_flush != {CntW{1'b1}})) m_flush = m_flush + 1'b1;
    if (to_next) m_to = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    s = '0;
    rs1_id = '0; rs2_id = '0; use_rs1_id = 0; use_rs2_id = 0; rd_idex = '0;
    mem_read_idex = 0; md_op_idex = 0; md_done = 0; dmem_req_exmem = 0;
    dmem_ready = 0; branch_taken_ex = 0;
    rstn = 1'b1;
    #3 rstn = 1'b0;
    #2;
    check_eq("rst_outs", 32'({outs, md_timeout}), 32'd0);
    check_eq("rst_stall", 32'(stall_cnt), 32'd0);
    check_eq("rst_flush", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    step(ONorm, 0);
    step(ONorm, 0);

    // Load-use on rs2, then the bubble is in EX.
    s = '0; s.mr = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1; step(OLoadUse, 0);
    s = '0; step(ONorm, 0);
    s = '0; s.mr = 1; s.rd = 0; s.rs2 = 0; s.u2 = 1; step(ONorm, 0);
    s = '0; s.mr = 1; s.rd = 7; s.rs1 = 7; s.u1 = 1; step(OLoadUse, 0);
    s = '0; s.mr = 1; s.rd = 7; s.rs1 = 7; s.u1 = 0; step(ONorm, 0);

    // Branch wins over load-use.
    s = '0; s.mr = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1; s.br = 1; step(OBranch, 0);
    s = '0; step(ONorm, 0);

    // MUL/DIV with a simultaneous branch; done arrives on the fifth MD_WAIT cycle.
    s = '0; s.md = 1; s.br = 1; step(OMdStart, 0);
    s = '0; s.md = 1;
    for (int i = 0; i < 4; i++) step(OMdWait, 0);
    s.mdd = 1; step(ONorm, 0);
    s = '0; step(ONorm, 0);
    s = '0; s.mdd = 1; step(ONorm, 0);

    // Watchdog: md_done never comes.
    s = '0; s.md = 1; step(OMdStart, 0);
    for (int i = 0; i < MdMax - 1; i++) step(OMdWait, 0);
    step(ONorm, 1);
    s = '0; step(ONorm, 0);

    // Memory wait overrides branch and load-use.
    s = '0; s.dreq = 1; s.br = 1; s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; step(OHold, 0);
    step(OHold, 0);
    step(OHold, 0);
    s.drdy = 1; step(ONorm, 0);
    s = '0; s.br = 1; step(OBranch, 0);
    s = '0; step(ONorm, 0);
    s = '0; s.dreq = 1; s.drdy = 1; step(ONorm, 0);

    // Run flush_cnt into saturation.
    s = '0; s.br = 1;
    for (int i = 0; i < 14; i++) step(OBranch, 0);
    s = '0; step(ONorm, 0);
    step(ONorm, 0);

    // Reset in the middle of an MD wait.
    s = '0; s.md = 1; step(OMdStart, 0);
    step(OMdWait, 0);
    drain();
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check_eq("midrst_outs", 32'({outs, md_timeout}), 32'd0);
    check_eq("midrst_stall", 32'(stall_cnt), 32'd0);
    check_eq("midrst_flush", 32'(flush_cnt), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    md_op_idex = 1'b0;
    #2;
    check_eq("postrst_outs", 32'({outs, md_timeout}), 32'({ONorm, 1'b0}));
    check_eq("postrst_stall", 32'(stall_cnt), 32'd0);
    check_eq("postrst_flush", 32'(flush_cnt), 32'd0);
    m_stall = '0; m_flush = '0; m_to = 1'b0;
    s = '0; step(ONorm, 0);
    step(ONorm, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
